// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns stage, one column per clock.
//
// Flow: a 128-bit state is accepted over in_valid/in_ready and captured.
// The four columns are then mixed over four BUSY cycles. The result is
// offered over out_valid/out_ready and held until it is taken.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer that raises valid keeps its data
// stable until that edge. Ready may depend on the other side's ready. Here,
// in_ready follows out_ready while a finished result is waiting in DONE, so
// a new block can enter on the same edge that the previous result leaves.
//
// Byte layout: column c = bits [127-32c -: 32]; the row 0 byte is the MSB
// of each column.
//
// Optional build macro INV_MIX_COLUMNS_EN: adds the `inverse` input. The
// input is captured on the accept edge, and when it is 1 the block applies
// InvMixColumns instead of MixColumns.

// Four-term GF(2^8) dot product: y = c0*a0 ^ c1*a1 ^ c2*a2 ^ c3*a3 (poly 0x11B).
module gf_dot4 (
   input  logic [7:0] a0,
   input  logic [7:0] a1,
   input  logic [7:0] a2,
   input  logic [7:0] a3,
   input  logic [7:0] c0,
   input  logic [7:0] c1,
   input  logic [7:0] c2,
   input  logic [7:0] c3,
   output logic [7:0] y
);

   // Shift-and-add GF(2^8) multiply with xtime reduction by 0x1B.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return p;
   endfunction

   // Sum of the four products.
   always_comb begin
      y = gf_mul(a0, c0) ^ gf_mul(a1, c1) ^ gf_mul(a2, c2) ^ gf_mul(a3, c3);
   end

endmodule

module mix_columns_iter #(
   parameter int NUM_COLS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
`ifdef INV_MIX_COLUMNS_EN
   ,
   input  logic         inverse
`endif
);

   // AES state is always four columns; anything else is a build error.
   if (NUM_COLS != 4) begin : g_bad_num_cols
      $error("mix_columns_iter: NUM_COLS must be 4");
   end

   localparam int COL_W = 2;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [COL_W-1:0]  col_q;
   logic [127:0]      in_q;
   logic [127:0]      res_q;
   logic              accept;
   logic [31:0]       col_word;
   logic [7:0]        s [4];
   logic [7:0]        mixed [4];
   logic [7:0]        base [4];

   // A block enters on any edge where the input handshake completes.
   assign accept = in_valid && in_ready;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------

   // State register; reset has priority over a handshake on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = BUSY;
         end
         BUSY: begin
            if (col_q == LAST_COL) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = in_valid ? BUSY : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake and status outputs, decoded from the current state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: in_ready = 1'b1;
         BUSY: busy     = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------

   // Capture the input on accept; write one mixed column per BUSY edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_q  <= 128'h0;
         res_q <= 128'h0;
         col_q <= '0;
      end else if (accept) begin
         in_q  <= in_data;
         col_q <= '0;
      end else if (state_q == BUSY) begin
         case (col_q)
            2'd0:    res_q[127:96] <= {mixed[0], mixed[1], mixed[2], mixed[3]};
            2'd1:    res_q[95:64]  <= {mixed[0], mixed[1], mixed[2], mixed[3]};
            2'd2:    res_q[63:32]  <= {mixed[0], mixed[1], mixed[2], mixed[3]};
            default: res_q[31:0]   <= {mixed[0], mixed[1], mixed[2], mixed[3]};
         endcase
         col_q <= col_q + 1'b1;
      end
   end

   // Select the column currently being mixed and split it into row bytes.
   always_comb begin
      case (col_q)
         2'd0:    col_word = in_q[127:96];
         2'd1:    col_word = in_q[95:64];
         2'd2:    col_word = in_q[63:32];
         default: col_word = in_q[31:0];
      endcase
      s[0] = col_word[31:24];
      s[1] = col_word[23:16];
      s[2] = col_word[15:8];
      s[3] = col_word[7:0];
   end

`ifdef INV_MIX_COLUMNS_EN
   logic inv_q;

   // Direction is latched with the block so it cannot change mid-flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inv_q <= 1'b0;
      end else if (accept) begin
         inv_q <= inverse;
      end
   end

   // Row 0 coefficients; the other rows are rotations of this one.
   always_comb begin
      if (inv_q) begin
         base[0] = 8'h0e;
         base[1] = 8'h0b;
         base[2] = 8'h0d;
         base[3] = 8'h09;
      end else begin
         base[0] = 8'h02;
         base[1] = 8'h03;
         base[2] = 8'h01;
         base[3] = 8'h01;
      end
   end
`else
   // Row 0 coefficients; the other rows are rotations of this one.
   always_comb begin
      base[0] = 8'h02;
      base[1] = 8'h03;
      base[2] = 8'h01;
      base[3] = 8'h01;
   end
`endif

   // One dot-product instance per output row; row r uses base rotated right by r.
   for (genvar r = 0; r < 4; r++) begin : g_row
      gf_dot4 u_dot (
         .a0 (s[0]),
         .a1 (s[1]),
         .a2 (s[2]),
         .a3 (s[3]),
         .c0 (base[(4 - r) % 4]),
         .c1 (base[(5 - r) % 4]),
         .c2 (base[(6 - r) % 4]),
         .c3 (base[(7 - r) % 4]),
         .y  (mixed[r])
      );
   end

   assign out_data = res_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: directed vectors plus randomized traffic for
// mix_columns_iter, checked every cycle against a behavioural model.
module tb_mix_columns_iter;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
`ifdef INV_MIX_COLUMNS_EN
   logic         inverse;
`endif

   int n_vec;
   int n_err;

   localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] VEC2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
   localparam logic [127:0] VEC2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

   mix_columns_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef INV_MIX_COLUMNS_EN
      ,
      .inverse   (inverse)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int x;
      int y;
      int p;
      x = a;
      y = b;
      p = 0;
      while (y != 0) begin
         if (y % 2 == 1) p = p ^ x;
         x = x * 2;
         if (x >= 256) x = x ^ 'h11b;
         y = y / 2;
      end
      return p[7:0];
   endfunction

   function automatic logic [127:0] mix_state(input logic [127:0] st, input bit inv);
      logic [7:0]   m [4][4];
      logic [7:0]   b [4][4];
      logic [7:0]   acc;
      logic [127:0] res;
      // Standard matrices written out row by row.
      m[0] = '{8'h02, 8'h03, 8'h01, 8'h01};
      m[1] = '{8'h01, 8'h02, 8'h03, 8'h01};
      m[2] = '{8'h01, 8'h01, 8'h02, 8'h03};
      m[3] = '{8'h03, 8'h01, 8'h01, 8'h02};
      if (inv) begin
         m[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
         m[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
         m[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
         m[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[c][r] = st[127 - 32*c - 8*r -: 8];
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[r][j], b[c][j]);
            res[127 - 32*c - 8*r -: 8] = acc;
         end
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / compare process ----------------
   logic [127:0] exp_q[$];
   int  edge_cnt;
   bit  armed;
   bit  last_rst_low;
   bit  m_out;
   int  m_due;

   // Edge bookkeeping: count edges and note whether the edge applied reset.
   always @(posedge clk) begin
      edge_cnt++;
      last_rst_low = !rst_n;
      if (!rst_n) armed = 1'b1;
   end

   // Per-cycle comparison, then advance the model by the coming edge.
   always @(negedge clk) begin
      bit ready_now;
      bit e_in_ready;
      bit in_fire;
      bit out_fire;
      bit inv_now;
      if (armed) begin
         ready_now  = m_out && (edge_cnt >= m_due);
         e_in_ready = !m_out || (ready_now && out_ready);
         chk("out_valid", {127'b0, out_valid}, {127'b0, ready_now});
         chk("busy",      {127'b0, busy},      {127'b0, m_out && !ready_now});
         chk("in_ready",  {127'b0, in_ready},  {127'b0, e_in_ready});
         if (last_rst_low) chk("out_data_reset", out_data, 128'h0);
         if (ready_now && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
         if (!rst_n) begin
            m_out = 1'b0;
            exp_q.delete();
         end else begin
            out_fire = ready_now && out_ready;
            in_fire  = in_valid && e_in_ready;
`ifdef INV_MIX_COLUMNS_EN
            inv_now = inverse;
`else
            inv_now = 1'b0;
`endif
            if (out_fire) begin
               m_out = 1'b0;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_fire) begin
               m_out = 1'b1;
               m_due = edge_cnt + 5;
               exp_q.push_back(mix_state(in_data, inv_now));
            end
         end
      end
   end

   // ---------------- drivers ----------------
   bit rand_ready;

   // Random downstream backpressure when enabled.
   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Offer one block; returns at posedge+1 after the accept edge.
   task automatic send_block(input logic [127:0] data);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = data;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 128'd0, 128'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Wait (bounded) for out_valid and check the result against a literal.
   task automatic wait_out(input string name, input logic [127:0] exp);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({name, "_timeout"}, 128'd0, 128'd1);
      else     chk(name, out_data, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_vec      = 0;
      n_err      = 0;
      rand_ready = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 128'h0;
      out_ready  = 1'b1;
`ifdef INV_MIX_COLUMNS_EN
      inverse    = 1'b0;
`endif

      // Pin the model with the published vectors.
      chk("model_fips", mix_state(FIPS_IN, 1'b0), FIPS_OUT);
      chk("model_vec2", mix_state(VEC2_IN, 1'b0), VEC2_OUT);
      chk("model_inv",  mix_state(FIPS_OUT, 1'b1), FIPS_IN);

      // Reset and idle.
      idle_cycles(3);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_out_valid", {127'b0, out_valid}, 128'd0);
      chk("idle_in_ready",  {127'b0, in_ready},  128'd1);
      chk("idle_out_data",  out_data, 128'h0);
      @(posedge clk);
      #1;

      // Directed vectors.
      send_block(FIPS_IN);
      wait_out("fips_out", FIPS_OUT);
      send_block(VEC2_IN);
      wait_out("vec2_out", VEC2_OUT);

      // Backpressure: result held, new block waits, then enters on release.
      out_ready = 1'b0;
      send_block(FIPS_IN);
      wait_out("bp_first", FIPS_OUT);
      in_valid = 1'b1;
      in_data  = VEC2_IN;
      repeat (10) @(negedge clk);
      chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
      chk("bp_hold",     out_data, FIPS_OUT);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 128'h0;
      wait_out("bp_second", VEC2_OUT);

      // Reset while column 2 is pending.
      send_block(FIPS_IN);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", {127'b0, out_valid}, 128'd0);
      chk("rst_mid_data",  out_data, 128'h0);
      @(posedge clk);
      #1;
      send_block(VEC2_IN);
      wait_out("after_rst", VEC2_OUT);

`ifdef INV_MIX_COLUMNS_EN
      inverse = 1'b1;
      send_block(FIPS_OUT);
      inverse = 1'b0;
      wait_out("inv_fips", FIPS_IN);
`endif

      // Back-to-back with continuous acceptance.
      for (int i = 0; i < 6; i++) send_block({$urandom, $urandom, $urandom, $urandom});
      idle_cycles(8);

      // Randomized traffic with random backpressure and gaps.
      rand_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         idle_cycles($urandom_range(0, 3));
`ifdef INV_MIX_COLUMNS_EN
         inverse = $urandom_range(0, 1) == 1;
`endif
         send_block({$urandom, $urandom, $urandom, $urandom});
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      idle_cycles(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
